// File: rtl/payload_char_class_decoder.sv
// Payload byte stream to per-class match lines for the payload regex engines.
// Class 0 is the start-of-data anchor; classes 1..NUM_CLASSES-1 are programmable.
module payload_char_class_decoder #(
    parameter int NUM_CLASSES = 40,
    parameter int ADDR_W      = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [7:0]             cfg_lo0,
    input  logic [7:0]             cfg_hi0,
    input  logic [7:0]             cfg_lo1,
    input  logic [7:0]             cfg_hi1,
    input  logic                   cfg_nocase,
    output logic                   cfg_err,
    output logic                   sod,
    output logic                   en,
    output logic [NUM_CLASSES-1:0] cls,
    output logic                   eop
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SOD    = 2'd1,
        ST_FIRST  = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic [7:0] lo0_r [NUM_CLASSES];
    logic [7:0] hi0_r [NUM_CLASSES];
    logic [7:0] lo1_r [NUM_CLASSES];
    logic [7:0] hi1_r [NUM_CLASSES];
    logic       nocase_r [NUM_CLASSES];

    logic                   s_ready_s;
    logic                   accept_s;
    logic                   wr_ok_s;
    logic                   err_s;
    logic                   addr_ok_s;
    logic [NUM_CLASSES-1:0] match_s;

    logic                   en_r;
    logic                   eop_r;
    logic                   sod_r;
    logic                   cfg_err_r;
    logic [NUM_CLASSES-1:0] cls_r;

    function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic logic is_alpha(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    // A letter under nocase is also tested with its case bit flipped.
    function automatic logic class_hit(input logic [7:0] c,
                                       input logic [7:0] lo0, input logic [7:0] hi0,
                                       input logic [7:0] lo1, input logic [7:0] hi1,
                                       input logic nc);
        logic [7:0] alt;
        logic       hit;
        alt = c ^ 8'h20;
        hit = in_range(c, lo0, hi0) || in_range(c, lo1, hi1);
        if (nc && is_alpha(c)) begin
            hit = hit || in_range(alt, lo0, hi0) || in_range(alt, lo1, hi1);
        end else begin
            hit = hit;
        end
        return hit;
    endfunction

    assign addr_ok_s = (cfg_addr != {ADDR_W{1'b0}}) &&
                       (32'(cfg_addr) < 32'(NUM_CLASSES));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, handshake and config-write arbitration
    always_comb begin
        next_state_s = state_r;
        s_ready_s    = 1'b0;
        accept_s     = 1'b0;
        wr_ok_s      = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_we) begin
                    if (addr_ok_s) begin
                        wr_ok_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    s_ready_s = 1'b1;
                    if (s_valid) begin
                        next_state_s = ST_SOD;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
            end
            ST_SOD: begin
                err_s        = cfg_we;
                next_state_s = ST_FIRST;
            end
            ST_FIRST, ST_STREAM: begin
                s_ready_s = 1'b1;
                err_s     = cfg_we;
                if (s_valid) begin
                    accept_s = 1'b1;
                    if (s_last) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_STREAM;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Class table; entry 0 is never written since class 0 is the anchor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                lo0_r[i]    <= 8'hFF;
                hi0_r[i]    <= 8'h00;
                lo1_r[i]    <= 8'hFF;
                hi1_r[i]    <= 8'h00;
                nocase_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i < NUM_CLASSES; i++) begin
                if (wr_ok_s && (cfg_addr == ADDR_W'(i))) begin
                    lo0_r[i]    <= cfg_lo0;
                    hi0_r[i]    <= cfg_hi0;
                    lo1_r[i]    <= cfg_lo1;
                    hi1_r[i]    <= cfg_hi1;
                    nocase_r[i] <= cfg_nocase;
                end
            end
        end
    end

    // Per-class match of the byte currently on s_data
    always_comb begin
        match_s = {NUM_CLASSES{1'b0}};
        for (int i = 1; i < NUM_CLASSES; i++) begin
            match_s[i] = class_hit(s_data, lo0_r[i], hi0_r[i], lo1_r[i], hi1_r[i],
                                   nocase_r[i]);
        end
    end

    // Output registers: one cycle from accept to en/cls/eop; cls holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r      <= 1'b0;
            eop_r     <= 1'b0;
            sod_r     <= 1'b0;
            cfg_err_r <= 1'b0;
            cls_r     <= {NUM_CLASSES{1'b0}};
        end else begin
            en_r      <= accept_s;
            eop_r     <= accept_s && s_last;
            sod_r     <= (next_state_s == ST_SOD);
            cfg_err_r <= err_s;
            if (accept_s) begin
                cls_r <= {match_s[NUM_CLASSES-1:1], (state_r == ST_FIRST)};
            end
        end
    end

    // s_ready is combinational on cfg_we, so it is gated to stay low in reset.
    assign s_ready = s_ready_s & rst_n;
    assign en      = en_r;
    assign eop     = eop_r;
    assign sod     = sod_r;
    assign cfg_err = cfg_err_r;
    assign cls     = cls_r;

endmodule
